// File: rtl/bsg_noc_pkg.sv
// Shared mesh NoC definitions: direction encoding and direction count.
// Used by the DOR decoder and the output arbiter.
package bsg_noc_pkg;
  typedef enum logic [2:0] {
    P = 3'd0,
    W = 3'd1,
    E = 3'd2,
    N = 3'd3,
    S = 3'd4
  } dir_e;

  localparam int dirs_lp = 5;
endpackage

// File: rtl/bsg_mesh_router_rr_arb.sv
// Round-robin arbiter for one router output.
// Priority starts at ptr_r; the pick runs on a doubled request vector.
module bsg_mesh_router_rr_arb #(
  parameter int dirs_p = 5
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic [dirs_p-1:0] reqs_i,
  input  logic              en_i,
  output logic [dirs_p-1:0] grant_o,
  output logic              v_o
);
  localparam int PW = (dirs_p > 1) ? $clog2(dirs_p) : 1;

  logic [PW-1:0]       r_ptr;
  logic [2*dirs_p-1:0] w_dbl;
  logic [2*dirs_p-1:0] w_mask;
  logic [PW-1:0]       w_gidx;
  logic                w_any;

  always_comb begin
    w_dbl  = {reqs_i, reqs_i};
    w_mask = '0;
    w_any  = 1'b0;
    w_gidx = '0;
    for (int j = 0; j < 2*dirs_p; j++) begin
      w_mask[j] = w_dbl[j] & (j >= int'(r_ptr));
    end
    // The upper copy covers the wrap-around past dirs_p-1.
    for (int j = 0; j < 2*dirs_p; j++) begin
      if (w_mask[j] && !w_any) begin
        w_any  = 1'b1;
        w_gidx = PW'(j % dirs_p);
      end
    end
    grant_o = '0;
    if (en_i && w_any) grant_o[w_gidx] = 1'b1;
    v_o = en_i & w_any;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_ptr <= '0;
    end else if (v_o) begin
      r_ptr <= (w_gidx == PW'(dirs_p-1)) ? '0 : w_gidx + PW'(1);
    end
  end
endmodule

// File: rtl/bsg_mesh_router_output_arb.sv
// Mesh router output stage: per-output round-robin grant, yumi return,
// and a one-entry registered slot per direction.
module bsg_mesh_router_output_arb
  import bsg_noc_pkg::*;
#(
  parameter int dirs_p  = dirs_lp,
  parameter int width_p = 32
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [dirs_p*dirs_p-1:0]  req_i,
  input  logic [dirs_p*width_p-1:0] data_i,
  output logic [dirs_p-1:0]         yumi_o,
  output logic [dirs_p-1:0]         v_o,
  output logic [dirs_p*width_p-1:0] data_o,
  input  logic [dirs_p-1:0]         ready_i
);
  logic [dirs_p-1:0]  w_row   [dirs_p];
  logic [dirs_p-1:0]  w_pick  [dirs_p];
  logic [dirs_p-1:0]  w_col   [dirs_p];
  logic [dirs_p-1:0]  w_grant [dirs_p];
  logic [width_p-1:0] w_dmux  [dirs_p];
  logic [width_p-1:0] r_data  [dirs_p];
  logic [dirs_p-1:0]  w_win;
  logic [dirs_p-1:0]  w_accept;
  logic [dirs_p-1:0]  w_yumi;
  logic [dirs_p-1:0]  r_full;

  always_comb begin
    for (int i = 0; i < dirs_p; i++) begin
      for (int o = 0; o < dirs_p; o++) begin
        w_row[i][o] = req_i[i*dirs_p+o] &
                      ((i == int'(P)) || (i != o));
      end
      // Lowest set bit only, so one input never wins twice.
      w_pick[i] = w_row[i] &
                  (~w_row[i] + {{(dirs_p-1){1'b0}}, 1'b1});
    end
    for (int o = 0; o < dirs_p; o++) begin
      for (int i = 0; i < dirs_p; i++) begin
        w_col[o][i] = w_pick[i][o];
      end
    end
  end

  assign w_accept = ~r_full | ready_i;

  for (genvar o = 0; o < dirs_p; o++) begin : g_out
    bsg_mesh_router_rr_arb #(
      .dirs_p(dirs_p)
    ) u_arb (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .reqs_i   (w_col[o]),
      .en_i     (w_accept[o]),
      .grant_o  (w_grant[o]),
      .v_o      (w_win[o])
    );
    assign data_o[o*width_p +: width_p] = r_data[o];
  end

  always_comb begin
    w_yumi = '0;
    for (int o = 0; o < dirs_p; o++) begin
      w_dmux[o] = '0;
      for (int i = 0; i < dirs_p; i++) begin
        if (w_grant[o][i]) w_dmux[o] = data_i[i*width_p +: width_p];
      end
      w_yumi = w_yumi | w_grant[o];
    end
  end

  assign yumi_o = reset_n_i ? w_yumi : '0;
  assign v_o    = r_full;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_full <= '0;
      for (int o = 0; o < dirs_p; o++) r_data[o] <= '0;
    end else begin
      for (int o = 0; o < dirs_p; o++) begin
        if (w_win[o]) begin
          r_data[o] <= w_dmux[o];
          r_full[o] <= 1'b1;
        end else if (w_accept[o]) begin
          r_full[o] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < dirs_p; i++) begin
      if (reset_n_i)
        assert ($onehot0(w_row[i]))
        else $warning("input %0d requests several outputs", i);
    end
  end
endmodule

// File: tb/tb_bsg_mesh_router_output_arb.sv
// Scoreboard bench: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_bsg_mesh_router_output_arb;
  localparam int D  = 5;
  localparam int WD = 32;

  logic              clk;
  logic              rst_n;
  logic [D*D-1:0]    req;
  logic [D*WD-1:0]   din_bus;
  logic [D-1:0]      yumi;
  logic [D-1:0]      v;
  logic [D*WD-1:0]   dout;
  logic [D-1:0]      rdy;
  logic [WD-1:0]     din [D];

  typedef struct {
    int         id;
    logic [4:0] yumi;
    logic [4:0] v;
    int         o;
    logic [31:0] d;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_step = 0;

  assign din_bus = {din[4], din[3], din[2], din[1], din[0]};

  bsg_mesh_router_output_arb #(
    .dirs_p (D),
    .width_p(WD)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .req_i    (req),
    .data_i   (din_bus),
    .yumi_o   (yumi),
    .v_o      (v),
    .data_o   (dout),
    .ready_i  (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic r, input logic [24:0] rq,
                      input logic [4:0] rd, input logic [4:0] ey,
                      input logic [4:0] ev, input int eo,
                      input logic [31:0] ed);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r;
    req   = rq;
    rdy   = rd;
    n_step++;
    e.id = n_step; e.yumi = ey; e.v = ev; e.o = eo; e.d = ed;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      n_chk++;
      if (yumi === e.yumi) n_pass++;
      else $display("FAIL yumi step %0d: got %b want %b",
                    e.id, yumi, e.yumi);
      n_chk++;
      if (v === e.v) n_pass++;
      else $display("FAIL v_o step %0d: got %b want %b",
                    e.id, v, e.v);
      if (e.o >= 0) begin
        n_chk++;
        if (dout[e.o*WD +: WD] === e.d) n_pass++;
        else $display("FAIL data_o[%0d] step %0d: got %h want %h",
                      e.o, e.id, dout[e.o*WD +: WD], e.d);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req   = '1;
    rdy   = '1;
    din[0] = 32'h11; din[1] = 32'hA5; din[2] = 32'h22;
    din[3] = 32'h33; din[4] = 32'h44;
    // reset with everything requesting
    step(0, 25'h1FFFFFF, 5'h1F, 5'b00000, 5'b00000, 0, 32'h0);
    step(0, 25'h1FFFFFF, 5'h1F, 5'b00000, 5'b00000, 0, 32'h0);
    step(1, 25'h1FFFFFF, 5'h1F, 5'b00001, 5'b00000, -1, 32'h0);
    step(1, 25'h0,       5'h1F, 5'b00000, 5'b00001, 0, 32'h11);
    // W->E single flit
    step(1, 25'h80,      5'h1F, 5'b00010, 5'b00000, -1, 32'h0);
    step(1, 25'h0,       5'h1F, 5'b00000, 5'b00100, 2, 32'hA5);
    // P,W,N -> P round robin, ptr0 starts at 1
    step(1, 25'h8021,    5'h1F, 5'b00010, 5'b00000, -1, 32'h0);
    step(1, 25'h8021,    5'h1F, 5'b01000, 5'b00001, 0, 32'hA5);
    step(1, 25'h8021,    5'h1F, 5'b00001, 5'b00001, 0, 32'h33);
    step(1, 25'h8021,    5'h1F, 5'b00010, 5'b00001, 0, 32'h11);
    step(1, 25'h0,       5'h1F, 5'b00000, 5'b00001, 0, 32'hA5);
    // backpressure on output 2
    step(1, 25'h80,      5'h1F, 5'b00010, 5'b00000, -1, 32'h0);
    step(1, 25'h80,      5'h1B, 5'b00000, 5'b00100, 2, 32'hA5);
    step(1, 25'h80,      5'h1B, 5'b00000, 5'b00100, 2, 32'hA5);
    step(1, 25'h80,      5'h1B, 5'b00000, 5'b00100, 2, 32'hA5);
    din[1] = 32'h5A;
    step(1, 25'h80,      5'h1F, 5'b00010, 5'b00100, 2, 32'hA5);
    step(1, 25'h0,       5'h1F, 5'b00000, 5'b00100, 2, 32'h5A);
    // U-turn ignored, then non-one-hot row
    step(1, 25'h40,      5'h1F, 5'b00000, 5'b00000, -1, 32'h0);
    step(1, 25'h40,      5'h1F, 5'b00000, 5'b00000, -1, 32'h0);
    step(1, 25'h280,     5'h1F, 5'b00010, 5'b00000, -1, 32'h0);
    step(1, 25'h0,       5'h1F, 5'b00000, 5'b00100, 2, 32'h5A);
    // fill every slot, then reset mid-cycle
    step(1, 25'h880881,  5'h00, 5'b11111, 5'b00000, -1, 32'h0);
    step(1, 25'h0,       5'h00, 5'b00000, 5'b11111, 3, 32'h44);
    step(0, 25'h1FFFFFF, 5'h1F, 5'b00000, 5'b00000, 3, 32'h0);
    step(0, 25'h1FFFFFF, 5'h1F, 5'b00000, 5'b00000, 2, 32'h0);
    step(1, 25'h1FFFFFF, 5'h1F, 5'b00001, 5'b00000, -1, 32'h0);
    step(1, 25'h0,       5'h1F, 5'b00000, 5'b00001, 0, 32'h11);
    repeat (3) @(posedge clk);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, want 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
